// File: rtl/dvp_frame_capture.sv
// DVP sensor capture: oversamples pclk/vsync/hsync/data in sys_clk, frames
// accepted images with a 3-byte header and streams pixel bytes to the FIFO.
module dvp_frame_capture #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_COLS    = 608,
  parameter int unsigned CNT_W       = 12
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pclk,
  input  logic             vsync,
  input  logic             hsync,
  input  logic [7:0]       data_in,
  input  logic             enable,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [7:0]       fifo_din,
  output logic             frame_start,
  output logic             frame_end,
  output logic             overflow,
  output logic [CNT_W-1:0] line_cnt,
  output logic [CNT_W-1:0] pix_cnt,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      drop_cnt
);

  localparam int unsigned Q_DEPTH = 4;
  localparam logic [7:0]  HDR0    = 8'hA5;
  localparam logic [7:0]  HDR1    = 8'h5A;

  typedef enum logic [2:0] {IDLE, WAIT_FRAME, HEADER, CAPTURE, DROP} state_t;

  logic [SYNC_STAGES-1:0]      pclk_sync, vsync_sync, hsync_sync;
  logic [SYNC_STAGES-1:0][7:0] data_sync;
  logic                        pclk_d, vsync_d, hsync_d;
  logic                        pclk_s, vsync_s, hsync_s;
  logic [7:0]                  data_s;
  logic                        pix_edge, vsync_rise, vsync_fall, hsync_fall;

  state_t                      state, state_nxt;
  logic [1:0]                  hdr_idx, hdr_idx_nxt;
  logic                        draining, draining_nxt;
  logic                        wr_en_nxt, fs_nxt, fe_nxt, ovf_nxt;
  logic [7:0]                  din_nxt, wr_byte;
  logic [CNT_W-1:0]            line_nxt, pix_nxt;
  logic [15:0]                 fcnt_nxt, drop_nxt;
  logic                        wr_req, push_req, drop_evt;

  logic [Q_DEPTH-1:0][7:0]     q_mem;
  logic [1:0]                  q_wr, q_rd;
  logic [2:0]                  q_cnt;
  logic                        q_push, q_pop, q_flush, q_full;

  // Input synchronizers; vsync resets high so a reset release never fakes a frame edge
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pclk_sync  <= '0;
      hsync_sync <= '0;
      vsync_sync <= '1;
      data_sync  <= '0;
      pclk_d     <= 1'b0;
      hsync_d    <= 1'b0;
      vsync_d    <= 1'b1;
    end else begin
      pclk_sync  <= {pclk_sync[SYNC_STAGES-2:0], pclk};
      hsync_sync <= {hsync_sync[SYNC_STAGES-2:0], hsync};
      vsync_sync <= {vsync_sync[SYNC_STAGES-2:0], vsync};
      data_sync  <= {data_sync[SYNC_STAGES-2:0], data_in};
      pclk_d     <= pclk_s;
      hsync_d    <= hsync_s;
      vsync_d    <= vsync_s;
    end
  end

  assign pclk_s     = pclk_sync[SYNC_STAGES-1];
  assign hsync_s    = hsync_sync[SYNC_STAGES-1];
  assign vsync_s    = vsync_sync[SYNC_STAGES-1];
  assign data_s     = data_sync[SYNC_STAGES-1];
  assign pix_edge   = pclk_s & ~pclk_d;
  assign vsync_rise = vsync_s & ~vsync_d;
  assign vsync_fall = ~vsync_s & vsync_d;
  assign hsync_fall = ~hsync_s & hsync_d;
  assign q_full     = (q_cnt == 3'(Q_DEPTH));

  // Small pixel queue absorbing pixels that arrive while the header is written
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      q_mem <= '0;
      q_wr  <= '0;
      q_rd  <= '0;
      q_cnt <= '0;
    end else if (q_flush) begin
      q_wr  <= '0;
      q_rd  <= '0;
      q_cnt <= '0;
    end else begin
      if (q_push) begin
        q_mem[q_wr] <= data_s;
        q_wr        <= q_wr + 2'd1;
      end
      if (q_pop) q_rd <= q_rd + 2'd1;
      q_cnt <= q_cnt + 3'(q_push) - 3'(q_pop);
    end
  end

  // State and registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      hdr_idx     <= '0;
      draining    <= 1'b0;
      fifo_wr_en  <= 1'b0;
      fifo_din    <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      overflow    <= 1'b0;
      line_cnt    <= '0;
      pix_cnt     <= '0;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      hdr_idx     <= hdr_idx_nxt;
      draining    <= draining_nxt;
      fifo_wr_en  <= wr_en_nxt;
      fifo_din    <= din_nxt;
      frame_start <= fs_nxt;
      frame_end   <= fe_nxt;
      overflow    <= ovf_nxt;
      line_cnt    <= line_nxt;
      pix_cnt     <= pix_nxt;
      frame_cnt   <= fcnt_nxt;
      drop_cnt    <= drop_nxt;
    end
  end

  // Next-state, write selection, counters and drop handling
  always_comb begin
    state_nxt    = state;
    hdr_idx_nxt  = hdr_idx;
    draining_nxt = draining;
    wr_en_nxt    = 1'b0;
    din_nxt      = fifo_din;
    fs_nxt       = 1'b0;
    fe_nxt       = 1'b0;
    ovf_nxt      = overflow;
    line_nxt     = line_cnt;
    pix_nxt      = pix_cnt;
    fcnt_nxt     = frame_cnt;
    drop_nxt     = drop_cnt;
    q_push       = 1'b0;
    q_pop        = 1'b0;
    q_flush      = 1'b0;
    wr_req       = 1'b0;
    wr_byte      = 8'h00;
    drop_evt     = 1'b0;
    push_req     = ((state == HEADER) || (state == CAPTURE)) && pix_edge && hsync_s &&
                   (pix_cnt < CNT_W'(MAX_COLS));

    case (state)
      IDLE: begin
        if (!vsync_s) state_nxt = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (vsync_rise && enable) begin
          fs_nxt       = 1'b1;
          fcnt_nxt     = frame_cnt + 16'd1;
          line_nxt     = '0;
          pix_nxt      = '0;
          ovf_nxt      = 1'b0;
          q_flush      = 1'b1;
          hdr_idx_nxt  = '0;
          draining_nxt = 1'b0;
          state_nxt    = HEADER;
        end
      end
      HEADER, CAPTURE: begin
        if (state == HEADER) begin
          wr_req = 1'b1;
          case (hdr_idx)
            2'd0:    wr_byte = HDR0;
            2'd1:    wr_byte = HDR1;
            default: wr_byte = frame_cnt[7:0];
          endcase
        end else if (q_cnt != 3'd0) begin
          wr_req  = 1'b1;
          wr_byte = q_mem[q_rd];
        end
        drop_evt = (wr_req && fifo_full) || (push_req && q_full);
        if (drop_evt) begin
          ovf_nxt      = 1'b1;
          q_flush      = 1'b1;
          draining_nxt = 1'b0;
          if (drop_cnt != 16'hFFFF) drop_nxt = drop_cnt + 16'd1;
          // frame_end was already reported if the frame had closed before the drop
          if (draining) begin
            state_nxt = WAIT_FRAME;
          end else if (vsync_fall) begin
            fe_nxt    = 1'b1;
            state_nxt = WAIT_FRAME;
          end else begin
            state_nxt = DROP;
          end
        end else begin
          if (wr_req) begin
            wr_en_nxt = 1'b1;
            din_nxt   = wr_byte;
            if (state == HEADER) begin
              hdr_idx_nxt = hdr_idx + 2'd1;
              if (hdr_idx == 2'd2) state_nxt = CAPTURE;
            end else begin
              q_pop = 1'b1;
            end
          end
          if (push_req) begin
            q_push  = 1'b1;
            pix_nxt = pix_cnt + CNT_W'(1);
          end
          if (hsync_fall) begin
            if (line_cnt != '1) line_nxt = line_cnt + CNT_W'(1);
            pix_nxt = '0;
          end
          if (vsync_fall) begin
            fe_nxt       = 1'b1;
            draining_nxt = 1'b1;
          end
          if ((state == CAPTURE) && draining && (q_cnt == 3'd0) && !push_req) begin
            draining_nxt = 1'b0;
            state_nxt    = WAIT_FRAME;
          end
        end
      end
      DROP: begin
        if (vsync_fall) begin
          fe_nxt    = 1'b1;
          state_nxt = WAIT_FRAME;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dvp_frame_capture.sv
// Randomized DVP frame stimulus checked against a byte-stream model of the capture path.
module tb_dvp_frame_capture;

  localparam int unsigned MAX_COLS = 608;
  localparam int unsigned CNT_W    = 12;

  logic             sys_clk;
  logic             sys_rst_n;
  logic             pclk, vsync, hsync, enable, fifo_full;
  logic [7:0]       data_in;
  logic             fifo_wr_en, frame_start, frame_end, overflow;
  logic [7:0]       fifo_din;
  logic [CNT_W-1:0] line_cnt, pix_cnt;
  logic [15:0]      frame_cnt, drop_cnt;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] wr_log[$];
  int         wr_total = 0;
  int         n_fs = 0, n_fe = 0, exp_fs = 0, exp_fe = 0;
  logic [15:0] exp_fcnt = 16'd0;
  logic [15:0] exp_drop = 16'd0;
  int         fe_lines = 0;
  bit         fe_drop  = 1'b0;
  int         mark;

  dvp_frame_capture #(
    .SYNC_STAGES(2),
    .MAX_COLS   (MAX_COLS),
    .CNT_W      (CNT_W)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .pclk       (pclk),
    .vsync      (vsync),
    .hsync      (hsync),
    .data_in    (data_in),
    .enable     (enable),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .overflow   (overflow),
    .line_cnt   (line_cnt),
    .pix_cnt    (pix_cnt),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < wr_log.size()) return 32'(wr_log[i]);
    return 32'hxxxx_xxxx;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},  32'(fifo_wr_en),  0);
    check({tag, "_din"},    32'(fifo_din),    0);
    check({tag, "_fs"},     32'(frame_start), 0);
    check({tag, "_fe"},     32'(frame_end),   0);
    check({tag, "_ovf"},    32'(overflow),    0);
    check({tag, "_line"},   32'(line_cnt),    0);
    check({tag, "_pix"},    32'(pix_cnt),     0);
    check({tag, "_fcnt"},   32'(frame_cnt),   0);
    check({tag, "_drop"},   32'(drop_cnt),    0);
  endtask

  // Compare process: every written byte against the model stream, plus frame pulses
  always @(posedge sys_clk) begin
    logic full_e;
    full_e = fifo_full;
    #1;
    if (sys_rst_n) begin
      if (fifo_wr_en) begin
        wr_total++;
        wr_log.push_back(fifo_din);
        check("wr_while_full", 32'(full_e), 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got byte 0x%0h, required no write", fifo_din);
        end else begin
          check("fifo_din", 32'(fifo_din), 32'(exp_q.pop_front()));
        end
      end
      if (frame_start) begin
        n_fs++;
        check("fs_frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
        check("fs_overflow",  32'(overflow),  0);
        check("fs_line_cnt",  32'(line_cnt),  0);
        check("fs_pix_cnt",   32'(pix_cnt),   0);
      end
      if (frame_end) begin
        n_fe++;
        if (fe_drop) begin
          check("fe_overflow_drop", 32'(overflow), 1);
          check("fe_drop_cnt",      32'(drop_cnt), 32'(exp_drop));
        end else begin
          check("fe_line_cnt", 32'(line_cnt), 32'(fe_lines));
          check("fe_overflow", 32'(overflow), 0);
        end
      end
    end
  end

  // One sensor pixel clock period; sensor updates signals while pclk is low
  task automatic pclk_cycle(input logic [7:0] d, input logic hs, input logic vs);
    pclk    = 1'b0;
    data_in = d;
    hsync   = hs;
    vsync   = vs;
    repeat ($urandom_range(3, 2)) @(negedge sys_clk);
    pclk = 1'b1;
    repeat ($urandom_range(3, 2)) @(negedge sys_clk);
  endtask

  // One sensor frame; the model appends the bytes the FIFO must receive
  task automatic run_frame(input int lines, input int cols, input logic [7:0] base, input bit en,
                           input int pre, input bit sim_fall, input int drop_after);
    int k, n, limit, tgt;
    bit chk_lines;
    chk_lines = en && (drop_after == 0);
    if (en) begin
      exp_fcnt++;
      exp_fs++;
      exp_fe++;
      limit = (drop_after > 0) ? drop_after : 1 << 30;
      n = 0;
      exp_q.push_back(8'hA5); n++;
      if (n < limit) begin exp_q.push_back(8'h5A); n++; end
      if (n < limit) begin exp_q.push_back(exp_fcnt[7:0]); n++; end
      k = 0;
      for (int l = 0; l < lines; l++) begin
        for (int c = 0; c < cols; c++) begin
          if (c < MAX_COLS && n < limit) begin
            exp_q.push_back(8'(base + 8'(k)));
            n++;
          end
          k++;
        end
      end
      if (drop_after > 0 && exp_drop != 16'hFFFF) exp_drop++;
      fe_lines = lines;
      fe_drop  = (drop_after > 0);
    end
    enable = en;
    repeat (4) @(negedge sys_clk);
    tgt = wr_total + drop_after;
    fork
      begin
        int kk;
        kk = 0;
        for (int p = 0; p < pre; p++) pclk_cycle(8'($urandom), 1'b0, 1'b1);
        for (int l = 0; l < lines; l++) begin
          for (int c = 0; c < cols; c++) begin
            pclk_cycle(8'(base + 8'(kk)), 1'b1, 1'b1);
            kk++;
          end
          if (chk_lines) begin
            repeat (6) @(negedge sys_clk);
            check("pix_cnt_eol", 32'(pix_cnt), (cols < MAX_COLS) ? 32'(cols) : 32'(MAX_COLS));
          end
          if (!en && l == 0) enable = 1'b1;
          if (!(sim_fall && l == lines - 1)) begin
            pclk_cycle(8'($urandom), 1'b0, 1'b1);
            pclk_cycle(8'($urandom), 1'b0, 1'b1);
            if (chk_lines) check("pix_cnt_clr", 32'(pix_cnt), 0);
          end
        end
        repeat (4) pclk_cycle(8'($urandom), 1'b0, 1'b0);
        repeat (8) @(negedge sys_clk);
      end
      begin
        if (drop_after > 0) begin
          for (int i = 0; i < 5000 && wr_total < tgt; i++) @(negedge sys_clk);
          n_checks++;
          if (wr_total >= tgt) begin
            fifo_full = 1'b1;
          end else begin
            n_fail++;
            $display("FAIL drop_trigger: got %0d writes, required %0d", wr_total, tgt);
          end
        end
      end
    join
    fifo_full = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 0);
    enable = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    pclk = 1'b0; vsync = 1'b0; hsync = 1'b0; data_in = 8'h00;
    enable = 1'b0; fifo_full = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("por");
    sys_rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);

    // Basic 3x4 frame
    mark = wr_log.size();
    run_frame(3, 4, 8'h10, 1'b1, 2, 1'b0, 0);
    check("t1_nbytes", 32'(wr_log.size() - mark), 15);
    check("t1_b0",  log_at(mark),      32'hA5);
    check("t1_b1",  log_at(mark + 1),  32'h5A);
    check("t1_b2",  log_at(mark + 2),  32'h01);
    check("t1_b3",  log_at(mark + 3),  32'h10);
    check("t1_b14", log_at(mark + 14), 32'h1B);
    check("t1_line_cnt",  32'(line_cnt),  3);
    check("t1_frame_cnt", 32'(frame_cnt), 1);
    check("t1_overflow",  32'(overflow),  0);
    check("t1_fs", 32'(n_fs), 1);
    check("t1_fe", 32'(n_fe), 1);

    // Pixels arriving during the header
    run_frame(2, 4, 8'h40, 1'b1, 1, 1'b0, 0);
    run_frame(2, 5, 8'h50, 1'b1, 0, 1'b1, 0);
    check("t2_overflow", 32'(overflow), 0);

    // FIFO full after 5 bytes, then a clean frame
    mark = wr_log.size();
    run_frame(3, 4, 8'h60, 1'b1, 2, 1'b0, 5);
    check("t3_nbytes",   32'(wr_log.size() - mark), 5);
    check("t3_overflow", 32'(overflow), 1);
    check("t3_drop_cnt", 32'(drop_cnt), 1);
    run_frame(3, 4, 8'h70, 1'b1, 1, 1'b0, 0);
    check("t3b_overflow", 32'(overflow), 0);
    check("t3b_drop_cnt", 32'(drop_cnt), 1);

    // Disabled at frame start, enabled mid-frame
    mark = wr_log.size();
    run_frame(2, 4, 8'h80, 1'b0, 1, 1'b0, 0);
    check("t4_nbytes", 32'(wr_log.size() - mark), 0);
    check("t4_frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
    run_frame(2, 3, 8'h90, 1'b1, 1, 1'b0, 0);

    // Line longer than MAX_COLS
    mark = wr_log.size();
    run_frame(1, 610, 8'h00, 1'b1, 1, 1'b0, 0);
    check("t5_nbytes", 32'(wr_log.size() - mark), 611);
    check("t5_pix_cnt_after", 32'(pix_cnt), 0);

    // Random frames
    for (int r = 0; r < 6; r++)
      run_frame(int'($urandom_range(3, 1)), int'($urandom_range(16, 1)), 8'($urandom), 1'b1,
                int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)), 0);

    // Reset released inside a frame
    enable = 1'b0;
    pclk_cycle(8'($urandom), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) pclk_cycle(8'($urandom), 1'b1, 1'b1);
    sys_rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    exp_fcnt = 16'd0;
    exp_drop = 16'd0;
    pclk_cycle(8'($urandom), 1'b1, 1'b1);
    pclk_cycle(8'($urandom), 1'b0, 1'b1);
    enable = 1'b1;
    mark = wr_log.size();
    sys_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) pclk_cycle(8'($urandom), (i % 3) != 2, 1'b1);
    repeat (3) pclk_cycle(8'($urandom), 1'b0, 1'b0);
    repeat (8) @(negedge sys_clk);
    check("rst_no_writes", 32'(wr_log.size() - mark), 0);
    mark = wr_log.size();
    run_frame(2, 3, 8'hC0, 1'b1, 1, 1'b0, 0);
    check("rst_hdr0", log_at(mark),     32'hA5);
    check("rst_hdr2", log_at(mark + 2), 32'h01);
    check("rst_frame_cnt", 32'(frame_cnt), 1);

    check("total_frame_start", 32'(n_fs), 32'(exp_fs));
    check("total_frame_end",   32'(n_fe), 32'(exp_fe));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
